// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-ported instruction memory between CPU fetch
// and a loader/debug port; every request gets its response exactly one cycle later.
module imem_arbiter #(
  parameter int SIZE = 512
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_f_req_valid,
  output logic                        o_f_req_ready,
  input  logic [31:0]                 i_f_addr,
  input  logic                        i_f_flush,
  output logic                        o_f_rsp_valid,
  output logic [31:0]                 o_f_rsp_data,
  output logic                        o_f_rsp_err,
  input  logic                        i_l_req_valid,
  output logic                        o_l_req_ready,
  input  logic                        i_l_we,
  input  logic [31:0]                 i_l_addr,
  input  logic [31:0]                 i_l_wdata,
  output logic                        o_l_rsp_valid,
  output logic [31:0]                 o_l_rsp_data,
  output logic                        o_l_rsp_err,
  output logic                        o_mem_en,
  output logic                        o_mem_we,
  output logic [$clog2(SIZE/4)-1:0]   o_mem_addr,
  output logic [31:0]                 o_mem_wdata,
  input  logic [31:0]                 i_mem_rdata
);
  localparam int          AW     = $clog2(SIZE/4);
  localparam logic [31:0] SIZE_B = 32'(SIZE);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic pend;
    logic owner_l;
    logic err;
    logic we;
    logic drop;
  } rsp_t;

  rsp_t        rsp_d, rsp_q;
  logic        last_l_d, last_l_q;
  logic        gnt_f, gnt_l, gnt, req_err;
  logic [31:0] req_addr, rsp_data;

  // Request side: grant, address check, memory drive and next response-stage state.
  always_comb begin
    gnt_f         = !i_rst && i_f_req_valid && (!i_l_req_valid || last_l_q);
    gnt_l         = !i_rst && i_l_req_valid && !gnt_f;
    gnt           = gnt_f || gnt_l;
    req_addr      = gnt_l ? i_l_addr : i_f_addr;
    req_err       = (req_addr[1:0] != 2'b00) || (req_addr >= SIZE_B);
    o_f_req_ready = gnt_f;
    o_l_req_ready = gnt_l;
    o_mem_en      = gnt && !req_err;
    o_mem_we      = o_mem_en && gnt_l && i_l_we;
    o_mem_addr    = o_mem_en ? req_addr[AW+1:2] : '0;
    o_mem_wdata   = o_mem_we ? i_l_wdata : '0;
    rsp_d.pend    = gnt;
    rsp_d.owner_l = gnt_l;
    rsp_d.err     = gnt && req_err;
    rsp_d.we      = gnt_l && i_l_we;
    // A flush in the accept cycle kills only the fetch response due next cycle.
    rsp_d.drop    = gnt_f && i_f_flush;
    last_l_d      = gnt ? gnt_l : last_l_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_q    <= '0;
      last_l_q <= 1'b1;
    end else begin
      rsp_q    <= rsp_d;
      last_l_q <= last_l_d;
    end
  end

  // Response side: memory read data arrives the cycle after o_mem_en, matching rsp_q.
  always_comb begin
    rsp_data      = rsp_q.err ? NOP : (rsp_q.we ? 32'h0 : i_mem_rdata);
    o_f_rsp_valid = !i_rst && rsp_q.pend && !rsp_q.owner_l && !rsp_q.drop;
    o_l_rsp_valid = !i_rst && rsp_q.pend && rsp_q.owner_l;
    o_f_rsp_data  = o_f_rsp_valid ? rsp_data : 32'h0;
    o_f_rsp_err   = o_f_rsp_valid && rsp_q.err;
    o_l_rsp_data  = o_l_rsp_valid ? rsp_data : 32'h0;
    o_l_rsp_err   = o_l_rsp_valid && rsp_q.err;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_imem_arbiter;
  localparam int SIZE = 512;
  localparam int NW   = SIZE / 4;
  localparam int AW   = $clog2(NW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst, i_f_req_valid, i_f_flush, i_l_req_valid, i_l_we;
  logic [31:0]   i_f_addr, i_l_addr, i_l_wdata, i_mem_rdata;
  logic          o_f_req_ready, o_f_rsp_valid, o_f_rsp_err;
  logic          o_l_req_ready, o_l_rsp_valid, o_l_rsp_err;
  logic [31:0]   o_f_rsp_data, o_l_rsp_data, o_mem_wdata;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;

  imem_arbiter #(.SIZE(SIZE)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_f_req_valid(i_f_req_valid), .o_f_req_ready(o_f_req_ready), .i_f_addr(i_f_addr),
    .i_f_flush(i_f_flush), .o_f_rsp_valid(o_f_rsp_valid), .o_f_rsp_data(o_f_rsp_data),
    .o_f_rsp_err(o_f_rsp_err),
    .i_l_req_valid(i_l_req_valid), .o_l_req_ready(o_l_req_ready), .i_l_we(i_l_we),
    .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata), .o_l_rsp_valid(o_l_rsp_valid),
    .o_l_rsp_data(o_l_rsp_data), .o_l_rsp_err(o_l_rsp_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) + 32'h0000_0007;
  endfunction

  // Environment memory: synchronous read, junk on the bus when not reading.
  int          cyc = 0;
  logic [31:0] mem_arr [NW];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < NW; i++) mem_arr[i] <= init_word(i);
      i_mem_rdata <= $urandom;
    end else if (o_mem_en && o_mem_we) begin
      mem_arr[o_mem_addr] <= o_mem_wdata;
      i_mem_rdata <= $urandom;
    end else if (o_mem_en) i_mem_rdata <= mem_arr[o_mem_addr];
    else i_mem_rdata <= $urandom;
  end

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t fq[$], lq[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state: the spec's memory contents and who was granted last.
  logic [31:0] ref_mem [NW];
  bit          last_l;

  task automatic step(input bit rst, input bit fv, input logic [31:0] fa, input bit fl,
                      input bit lv, input bit lwe, input logic [31:0] la,
                      input logic [31:0] lwd, output bit acc_f, output bit acc_l);
    logic [31:0] a, d;
    bit          e, wr;
    @(posedge clk); #1;
    i_rst = rst; i_f_req_valid = fv; i_f_addr = fa; i_f_flush = fl;
    i_l_req_valid = lv; i_l_we = lwe; i_l_addr = la; i_l_wdata = lwd;
    #1;
    acc_f = 1'b0; acc_l = 1'b0;
    if (rst) begin
      if (fq.size() > 0 && fq[0].due == cyc) void'(fq.pop_front());
      if (lq.size() > 0 && lq[0].due == cyc) void'(lq.pop_front());
      last_l = 1'b1;
    end else if (fv && lv) begin
      acc_f = last_l; acc_l = !last_l;
    end else begin
      acc_f = fv; acc_l = lv;
    end
    chk("f_req_ready", 32'(o_f_req_ready), 32'(acc_f));
    chk("l_req_ready", 32'(o_l_req_ready), 32'(acc_l));
    if (acc_f || acc_l) begin
      a  = acc_l ? la : fa;
      e  = (a % 4 != 0) || (a >= SIZE);
      wr = acc_l && lwe;
      chk("mem_en", 32'(o_mem_en), 32'(!e));
      if (!e) begin
        chk("mem_addr", 32'(o_mem_addr), a / 4);
        chk("mem_we", 32'(o_mem_we), 32'(wr));
        if (wr) chk("mem_wdata", o_mem_wdata, lwd);
      end
      d = e ? 32'h13 : (wr ? 32'h0 : ref_mem[a / 4]);
      if (wr && !e) ref_mem[a / 4] = lwd;
      if (acc_f && !fl) fq.push_back('{due: cyc + 1, data: d, err: e});
      if (acc_l) lq.push_back('{due: cyc + 1, data: d, err: e});
      last_l = acc_l;
    end else chk("mem_en_idle", 32'(o_mem_en), 32'h0);
  endtask

  // Monitor: compares whatever the DUT presents against the head of each queue.
  always @(negedge clk) begin
    if (o_f_rsp_valid) begin
      if (fq.size() == 0 || fq[0].due != cyc) chk("f_rsp_unexpected", 32'(o_f_rsp_valid), 32'h0);
      else begin
        chk("f_rsp_data", o_f_rsp_data, fq[0].data);
        chk("f_rsp_err", 32'(o_f_rsp_err), 32'(fq[0].err));
        void'(fq.pop_front());
      end
    end else if (fq.size() > 0 && fq[0].due <= cyc) begin
      chk("f_rsp_missing", 32'(o_f_rsp_valid), 32'h1);
      void'(fq.pop_front());
    end
    if (o_l_rsp_valid) begin
      if (lq.size() == 0 || lq[0].due != cyc) chk("l_rsp_unexpected", 32'(o_l_rsp_valid), 32'h0);
      else begin
        chk("l_rsp_data", o_l_rsp_data, lq[0].data);
        chk("l_rsp_err", 32'(o_l_rsp_err), 32'(lq[0].err));
        void'(lq.pop_front());
      end
    end else if (lq.size() > 0 && lq[0].due <= cyc) begin
      chk("l_rsp_missing", 32'(o_l_rsp_valid), 32'h1);
      void'(lq.pop_front());
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, SIZE - 1)) | 32'h1;
      1:       return 32'(SIZE) + 32'($urandom_range(0, 3)) * 4;
      2:       return 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, 15)) * 4;
    endcase
  endfunction

  bit af, al;
  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    last_l = 1'b1;
    i_rst = 1'b1; i_f_req_valid = 0; i_f_addr = 0; i_f_flush = 0;
    i_l_req_valid = 0; i_l_we = 0; i_l_addr = 0; i_l_wdata = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, af, al);
    step(1, 1, 0, 0, 1, 0, 0, 0, af, al);
    step(0, 0, 0, 0, 0, 0, 0, 0, af, al);
    chk("rst_f_rsp_valid", 32'(o_f_rsp_valid), 32'h0);
    chk("rst_f_rsp_data", o_f_rsp_data, 32'h0);
    chk("rst_l_rsp_data", o_l_rsp_data, 32'h0);
    chk("rst_l_rsp_err", 32'(o_l_rsp_err), 32'h0);

    // Fetch-only stream.
    for (int i = 0; i < 3; i++) step(0, 1, 32'(i * 4), 0, 0, 0, 0, 0, af, al);
    step(0, 0, 0, 0, 0, 0, 0, 0, af, al);

    // Both valid after reset: F, L, F, L.
    step(1, 0, 0, 0, 0, 0, 0, 0, af, al);
    step(0, 1, 32'h20, 0, 1, 0, 32'h40, 0, af, al);
    step(0, 1, 32'h24, 0, 1, 0, 32'h40, 0, af, al);
    step(0, 1, 32'h24, 0, 1, 0, 32'h44, 0, af, al);
    step(0, 1, 32'h28, 0, 1, 0, 32'h44, 0, af, al);

    // Same-word write/read race.
    step(1, 0, 0, 0, 0, 0, 0, 0, af, al);
    step(0, 1, 32'h10, 0, 1, 1, 32'h10, 32'hDEADBEEF, af, al);
    step(0, 1, 32'h10, 0, 1, 1, 32'h10, 32'hDEADBEEF, af, al);
    step(0, 1, 32'h10, 0, 0, 0, 0, 0, af, al);

    // Misaligned and out-of-range fetches.
    step(0, 1, 32'h6, 0, 0, 0, 0, 0, af, al);
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, af, al);

    // Flushed fetch, then flush while a loader read is in flight.
    step(0, 1, 32'h0, 1, 0, 0, 0, 0, af, al);
    step(0, 0, 0, 1, 1, 0, 32'h8, 0, af, al);
    step(0, 0, 0, 1, 0, 0, 0, 0, af, al);

    // Reset right after a loader read is accepted, then a tie.
    step(0, 0, 0, 0, 1, 0, 32'hC, 0, af, al);
    step(1, 0, 0, 0, 0, 0, 0, 0, af, al);
    step(0, 1, 32'h4, 0, 1, 0, 32'h8, 0, af, al);
    step(0, 0, 0, 0, 1, 0, 32'h8, 0, af, al);

    // Random traffic honouring the hold-while-stalled rule.
    begin
      bit          fv = 0, lv = 0, lwe = 0;
      logic [31:0] fa = 0, la = 0, lwd = 0;
      bit          rst = 0;
      for (int n = 0; n < 600; n++) begin
        if (rst || !fv || af) begin fv = ($urandom_range(0, 2) != 0); fa = rand_addr(); end
        if (rst || !lv || al) begin
          lv = ($urandom_range(0, 2) != 0); la = rand_addr();
          lwe = $urandom_range(0, 1); lwd = $urandom;
        end
        rst = ($urandom_range(0, 49) == 0);
        step(rst, fv, fa, ($urandom_range(0, 5) == 0), lv, lwe, la, lwd, af, al);
      end
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, af, al);
    @(posedge clk);
    if (fq.size() != 0 || lq.size() != 0) chk("queues_drained", 32'(fq.size() + lq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-ported, word-wide instruction memory between the CPU fetch stage and a loader/debug port.
- Arbitrates round-robin and checks alignment and range before any memory access.
- Issues at most one memory access per cycle and returns each response exactly one cycle after its request is accepted.
- Supports a fetch flush so stale fetch responses are dropped on redirect.

Parameters:
- SIZE, 512, instruction memory size in bytes; must be a power of two and at least 4.
- AW, $clog2(SIZE/4), derived localparam: width of the word address; not overridable.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_f_req_valid  in  1  fetch request valid.
- o_f_req_ready  out  1  fetch request accepted this cycle.
- i_f_addr  in  32  fetch byte address.
- i_f_flush  in  1  discard any fetch response due next cycle.
- o_f_rsp_valid  out  1  fetch response valid.
- o_f_rsp_data  out  32  fetch instruction word.
- o_f_rsp_err  out  1  fetch address was misaligned or out of range.
- i_l_req_valid  in  1  loader request valid.
- o_l_req_ready  out  1  loader request accepted this cycle.
- i_l_we  in  1  loader write (1) or read (0).
- i_l_addr  in  32  loader byte address.
- i_l_wdata  in  32  loader write data.
- o_l_rsp_valid  out  1  loader response valid.
- o_l_rsp_data  out  32  loader read data; 0 on writes.
- o_l_rsp_err  out  1  loader address error.
- o_mem_en  out  1  memory access strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW  memory word address.
- o_mem_wdata  out  32  memory write data.
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_en.

Behaviour:
- Handshake: a request is accepted in the cycle where valid && ready. The ready outputs are combinational from the valids and the grant pointer. Requesters must hold addr/we/wdata stable while valid && !ready.
- Arbitration: at most one port is granted per cycle. If only one port is valid, it is granted. If both are valid, the port not granted last time wins. The last-grant register updates only on an accepted request. Reset sets last-grant = loader, so fetch wins the first tie.
- Address check: err = (addr[1:0] != 0) || (addr >= SIZE). On err, o_mem_en stays 0 and no memory access or write occurs. The response is still returned next cycle with err = 1.
- Memory drive: for a valid accepted request, o_mem_en = 1, o_mem_addr = addr[AW+1:2], o_mem_we = i_l_we for the loader and 0 for fetch, o_mem_wdata = i_l_wdata. All memory outputs are 0 when there is no access.
- Response stage: one register holds rsp_pending, owner, err and we. A request accepted in cycle N gives rsp_valid for the owner in cycle N+1 only. Throughput is one request per cycle with no bubbles.
- Response data, selected from the registered owner/err/we:
  - read ok: data = i_mem_rdata, err = 0.
  - write ok: data = 0, err = 0.
  - err: data = 32'h00000013 (NOP), err = 1.
- No response backpressure: responses must be consumed in the cycle they are presented.
- Flush: if i_f_flush = 1 in cycle N, any fetch response due in N+1 is suppressed (o_f_rsp_valid = 0). A fetch request presented in the same cycle N is still arbitrated and accepted normally, and its response in N+1 is suppressed as well. Flush never affects loader responses.
- Reset (i_rst = 1 at the edge), including mid-operation:
  - rsp_pending cleared, so any in-flight response is dropped and all rsp_valid = 0 next cycle.
  - o_*_rsp_data = 0, o_*_rsp_err = 0, last-grant = loader.
  - While i_rst = 1, both readies are 0 and o_mem_en = 0.
- Simultaneous loader write and fetch read of the same word: both are never granted in the same cycle. The order of the two responses reflects grant order, and a fetch granted after the write returns the new data.

Test Plan:
- Reset then fetch-only stream at 0x0, 0x4, 0x8 over 3 consecutive cycles:
  - ready = 1 every cycle.
  - o_f_rsp_valid on cycles 2-4 with mem[0], mem[1], mem[2].
  - no loader response.
- Both ports valid for 4 cycles:
  - grants alternate F, L, F, L.
  - each response appears exactly 1 cycle after its grant on the matching port.
- Loader writes 0xDEADBEEF to 0x10 and fetch reads 0x10, both valid in the same cycle after reset:
  - fetch is granted first and returns the old word.
  - loader write is granted next; a repeat fetch then returns 0xDEADBEEF.
- Fetch at 0x6, and fetch at SIZE (0x200):
  - o_mem_en = 0 for each.
  - each response has err = 1 and data = 0x00000013.
- Fetch accepted in cycle N with i_f_flush = 1 in cycle N, then flush asserted again in cycle N+1 while a loader read is in flight:
  - o_f_rsp_valid = 0 in N+1.
  - the loader response is delivered normally.
- i_rst asserted the cycle after a loader read is accepted:
  - no o_l_rsp_valid is produced.
  - after reset deasserts, the first tie goes to fetch.
